im2col_tensor_addr: RTL and testbench
=====================================

# im2col_tensor_addr

Streams tensor-buffer read addresses in im2col column order for one convolution pass. It sits directly downstream of the parameter-preparation stage. It consumes that stage's `enable` level and the latched layer configuration, including the per-dimension output count minus one (`ofs`). It feeds the tensor read port and S2P packer one address per handshake, tagging S2P lane position and column boundaries.

## Interface
- `TENSOR_W`, default 8: width of `tensor_size` and `ofs`.
- `KERNEL_W`, default 4: width of `kernel_size`.
- `CHANNELS_W`, default 8: width of `channels`.
- `STRIDE_W`, default 4: width of `stride`.
- `ADDR_W`, default 16: tensor buffer address width.
- `S2P`, default 8: lanes per packed beat; must be a power of two, at least 2.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rstn`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: level from the prep stage; high means all configuration inputs are valid and stable.
- `tensor_size`, in, TENSOR_W: input height/width T (square).
- `kernel_size`, in, KERNEL_W: kernel height/width K.
- `channels`, in, CHANNELS_W: channel count C.
- `stride`, in, STRIDE_W: stride S.
- `ofs`, in, TENSOR_W: output positions per dimension minus 1.
- `t_addr`, out, ADDR_W: element address.
- `t_valid`, out, 1: `t_addr` and its tags are valid.
- `t_ready`, in, 1: the consumer accepts the address this cycle.
- `t_lane`, out, log2(S2P): lane index of this element within its S2P beat.
- `beat_last`, out, 1: last element of the current S2P beat.
- `col_last`, out, 1: last element of the current im2col column.
- `done`, out, 1: the pass is complete (level).

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE → LOAD when `enable`=1.
- LOAD lasts one cycle:
  - Latch T, K, C, S and `ofs`.
  - Compute `plane` = T*T and register it at 2*TENSOR_W bits.
  - Clear all counters.
- LOAD → DONE directly when K=0 or C=0 (zero beats). Otherwise LOAD → RUN.
- RUN nested order, outermost first: `orow` 0..ofs, `ocol` 0..ofs, `c` 0..C-1, `kr` 0..K-1, `kc` 0..K-1.
- Address: `t_addr` = c*plane + (orow*S + kr)*T + ocol*S + kc, truncated to ADDR_W bits (wraps modulo 2^ADDR_W).
  - Compute it incrementally with base registers: a row base, a column base, a channel base and the kernel offsets.
  - No multiplier in RUN; additions only.
- A handshake occurs when `t_valid` && `t_ready`. Counters, address and tags advance only on a handshake.
- `t_valid` is high throughout RUN. Address and tags hold stable while `t_ready`=0.
- `col_last` = 1 when c=C-1, kr=K-1 and kc=K-1.
- `t_lane` starts at 0 at each column start and increments per element, wrapping at S2P.
- `beat_last` = 1 when `t_lane`=S2P-1 or `col_last`=1.
- RUN → DONE on the handshake of the element where all counters are at their maximum.
- DONE holds `done`=1 until `enable`=0, then returns to IDLE.
- `enable`=0 in LOAD or RUN aborts to IDLE on the next edge. `t_valid` drops on that edge, no further handshakes occur, and `done` stays 0.
- Configuration inputs are ignored outside LOAD.

## Timing
- Reset values:
  - `t_addr`=0, `t_valid`=0, `t_lane`=0, `beat_last`=0, `col_last`=0, `done`=0.
  - FSM in IDLE; all counters and bases 0.
- First edge seeing `enable`=1 enters LOAD. The next edge enters RUN with `t_valid`=1 and `t_addr` equal to the first address (2 edges after `enable` is sampled).
- Throughput: 1 address per cycle with `t_ready` held high.
- Total beats = (ofs+1)^2 * K*K*C.
- `t_valid` falls and `done` rises on the edge after the final handshake.
- Reset asserted mid-RUN clears all state immediately and asynchronously. Outputs take their reset values with no partial-stream continuation.

## Test plan
- T=4, K=2, S=1, C=1, `ofs`=2, `t_ready`=1:
  - First 8 addresses are 0,1,4,5,1,2,5,6.
  - 36 handshakes in total; `col_last` on every 4th; `t_lane` cycles 0..3 with `beat_last` on lane 3.
  - `done` rises one cycle after the 36th handshake.
- T=5, K=3, S=2, C=1, `ofs`=1:
  - Column 0 is 0,1,2,5,6,7,10,11,12; column 1 is 2,3,4,7,8,9,12,13,14.
  - `beat_last` on the 8th element (lane 7) and the 9th element (lane 0, `col_last`).
- T=3, K=2, S=1, C=2, `ofs`=1:
  - Column 0 is 0,1,3,4,9,10,12,13.
  - Last column is 4,5,7,8,13,14,16,17; 32 beats total.
- Backpressure: the first T=4 case with `t_ready` toggling 1,0,0,1 repeatedly.
  - `t_addr` and tags are held stable during the 0 cycles.
  - The sequence is identical to the first case with no drops or duplicates.
- Abort and degenerate cases:
  - `enable` deasserted after the 5th handshake → `t_valid`=0 on the next edge, FSM returns to IDLE and `done` stays 0.
  - Re-asserting `enable` restarts at address 0.
  - With K=0, `done`=1 two cycles after `enable` and `t_valid` is never asserted.
- Async reset pulse mid-RUN: all outputs go to 0 within the reset pulse; after release with `enable`=1, the stream restarts from address 0.

Source files
------------

// File: rtl/im2col_tensor_addr.sv
// im2col address generator: walks orow/ocol/channel/kernel-row/kernel-col and emits one
// tensor-buffer address per valid/ready handshake, tagged with S2P lane and column boundaries.
module im2col_tensor_addr #(
   parameter int TENSOR_W   = 8,
   parameter int KERNEL_W   = 4,
   parameter int CHANNELS_W = 8,
   parameter int STRIDE_W   = 4,
   parameter int ADDR_W     = 16,
   parameter int S2P        = 8,
   localparam int LANE_W    = $clog2(S2P)
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  enable,
   input  logic [TENSOR_W-1:0]   tensor_size,
   input  logic [KERNEL_W-1:0]   kernel_size,
   input  logic [CHANNELS_W-1:0] channels,
   input  logic [STRIDE_W-1:0]   stride,
   input  logic [TENSOR_W-1:0]   ofs,
   output logic [ADDR_W-1:0]     t_addr,
   output logic                  t_valid,
   input  logic                  t_ready,
   output logic [LANE_W-1:0]     t_lane,
   output logic                  beat_last,
   output logic                  col_last,
   output logic                  done,
   output logic [1:0]            dbg_state
);

   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

   // Handshake: an address transfers on a rising edge where t_valid && t_ready; while
   // t_ready is low, t_addr and all tags hold their value and t_valid stays high.

   state_t                state_q, state_d;
   logic [TENSOR_W-1:0]   t_q, t_d;
   logic [KERNEL_W-1:0]   k_q, k_d;
   logic [CHANNELS_W-1:0] c_q, c_d;
   logic [TENSOR_W-1:0]   ofs_q, ofs_d;
   logic [2*TENSOR_W-1:0] plane_q, plane_d;
   logic [ADDR_W-1:0]     row_step_q, row_step_d;
   logic [STRIDE_W-1:0]   s_q, s_d;

   logic [TENSOR_W-1:0]   orow_q, orow_d, ocol_q, ocol_d;
   logic [CHANNELS_W-1:0] ch_q, ch_d;
   logic [KERNEL_W-1:0]   kr_q, kr_d, kc_q, kc_d;
   logic [LANE_W-1:0]     lane_q, lane_d;

   logic [ADDR_W-1:0]     row_base_q, row_base_d;
   logic [ADDR_W-1:0]     col_base_q, col_base_d;
   logic [ADDR_W-1:0]     ch_base_q, ch_base_d;
   logic [ADDR_W-1:0]     kr_off_q, kr_off_d;

   logic run, kc_last, kr_last, ch_last, ocol_last, orow_last, col_end;

   assign run       = (state_q == RUN);
   assign kc_last   = (kc_q == k_q - KERNEL_W'(1));
   assign kr_last   = (kr_q == k_q - KERNEL_W'(1));
   assign ch_last   = (ch_q == c_q - CHANNELS_W'(1));
   assign ocol_last = (ocol_q == ofs_q);
   assign orow_last = (orow_q == ofs_q);
   assign col_end   = kc_last && kr_last && ch_last;

   assign t_valid   = run;
   assign t_addr    = run ? (ch_base_q + row_base_q + kr_off_q + col_base_q + ADDR_W'(kc_q)) : '0;
   assign t_lane    = run ? lane_q : '0;
   assign col_last  = run && col_end;
   assign beat_last = run && (col_end || (lane_q == LANE_W'(S2P - 1)));
   assign done      = (state_q == DONE);
   assign dbg_state = state_q;

   always_comb begin
      state_d    = state_q;
      t_d        = t_q;
      k_d        = k_q;
      c_d        = c_q;
      s_d        = s_q;
      ofs_d      = ofs_q;
      plane_d    = plane_q;
      row_step_d = row_step_q;
      orow_d     = orow_q;
      ocol_d     = ocol_q;
      ch_d       = ch_q;
      kr_d       = kr_q;
      kc_d       = kc_q;
      lane_d     = lane_q;
      row_base_d = row_base_q;
      col_base_d = col_base_q;
      ch_base_d  = ch_base_q;
      kr_off_d   = kr_off_q;

      case (state_q)
         IDLE: begin
            if (enable) state_d = LOAD;
         end
         LOAD: begin
            t_d        = tensor_size;
            k_d        = kernel_size;
            c_d        = channels;
            s_d        = stride;
            ofs_d      = ofs;
            // The only multiplies live here; RUN advances the bases with adders alone.
            plane_d    = (2*TENSOR_W)'(tensor_size) * (2*TENSOR_W)'(tensor_size);
            row_step_d = ADDR_W'(stride) * ADDR_W'(tensor_size);
            orow_d     = '0;
            ocol_d     = '0;
            ch_d       = '0;
            kr_d       = '0;
            kc_d       = '0;
            lane_d     = '0;
            row_base_d = '0;
            col_base_d = '0;
            ch_base_d  = '0;
            kr_off_d   = '0;
            if (!enable) state_d = IDLE;
            else if (kernel_size == '0 || channels == '0) state_d = DONE;
            else state_d = RUN;
         end
         RUN: begin
            if (!enable) begin
               state_d = IDLE;
            end else if (t_ready) begin
               lane_d = col_end ? '0 : lane_q + LANE_W'(1);
               if (!kc_last) begin
                  kc_d = kc_q + KERNEL_W'(1);
               end else begin
                  kc_d = '0;
                  if (!kr_last) begin
                     kr_d     = kr_q + KERNEL_W'(1);
                     kr_off_d = kr_off_q + ADDR_W'(t_q);
                  end else begin
                     kr_d     = '0;
                     kr_off_d = '0;
                     if (!ch_last) begin
                        ch_d      = ch_q + CHANNELS_W'(1);
                        ch_base_d = ch_base_q + ADDR_W'(plane_q);
                     end else begin
                        ch_d      = '0;
                        ch_base_d = '0;
                        if (!ocol_last) begin
                           ocol_d     = ocol_q + TENSOR_W'(1);
                           col_base_d = col_base_q + ADDR_W'(s_q);
                        end else begin
                           ocol_d     = '0;
                           col_base_d = '0;
                           orow_d     = orow_q + TENSOR_W'(1);
                           row_base_d = row_base_q + row_step_q;
                           if (orow_last) state_d = DONE;
                        end
                     end
                  end
               end
            end
         end
         DONE: begin
            if (!enable) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         t_q        <= '0;
         k_q        <= '0;
         c_q        <= '0;
         s_q        <= '0;
         ofs_q      <= '0;
         plane_q    <= '0;
         row_step_q <= '0;
         orow_q     <= '0;
         ocol_q     <= '0;
         ch_q       <= '0;
         kr_q       <= '0;
         kc_q       <= '0;
         lane_q     <= '0;
         row_base_q <= '0;
         col_base_q <= '0;
         ch_base_q  <= '0;
         kr_off_q   <= '0;
      end else begin
         state_q    <= state_d;
         t_q        <= t_d;
         k_q        <= k_d;
         c_q        <= c_d;
         s_q        <= s_d;
         ofs_q      <= ofs_d;
         plane_q    <= plane_d;
         row_step_q <= row_step_d;
         orow_q     <= orow_d;
         ocol_q     <= ocol_d;
         ch_q       <= ch_d;
         kr_q       <= kr_d;
         kc_q       <= kc_d;
         lane_q     <= lane_d;
         row_base_q <= row_base_d;
         col_base_q <= col_base_d;
         ch_base_q  <= ch_base_d;
         kr_off_q   <= kr_off_d;
      end
   end

endmodule

// File: tb/tb_im2col_tensor_addr.sv
// Bench for im2col_tensor_addr: directed vector table with address probes, then random
// configurations and random backpressure checked against a nested-loop im2col model.
module tb_im2col_tensor_addr;

   localparam int TENSOR_W   = 8;
   localparam int KERNEL_W   = 4;
   localparam int CHANNELS_W = 8;
   localparam int STRIDE_W   = 4;
   localparam int ADDR_W     = 16;
   localparam int S2P        = 8;
   localparam int LW         = $clog2(S2P);
   localparam int EW         = ADDR_W + LW + 2;
   localparam int BUDGET     = 3000;

   logic                  clk = 1'b0;
   logic                  rstn;
   logic                  enable;
   logic [TENSOR_W-1:0]   tensor_size;
   logic [KERNEL_W-1:0]   kernel_size;
   logic [CHANNELS_W-1:0] channels;
   logic [STRIDE_W-1:0]   stride;
   logic [TENSOR_W-1:0]   ofs;
   logic [ADDR_W-1:0]     t_addr;
   logic                  t_valid;
   logic                  t_ready;
   logic [LW-1:0]         t_lane;
   logic                  beat_last;
   logic                  col_last;
   logic                  done;
   logic [1:0]            dbg_state;

   im2col_tensor_addr #(
      .TENSOR_W(TENSOR_W), .KERNEL_W(KERNEL_W), .CHANNELS_W(CHANNELS_W),
      .STRIDE_W(STRIDE_W), .ADDR_W(ADDR_W), .S2P(S2P)
   ) dut (
      .clk(clk), .rstn(rstn), .enable(enable),
      .tensor_size(tensor_size), .kernel_size(kernel_size), .channels(channels),
      .stride(stride), .ofs(ofs),
      .t_addr(t_addr), .t_valid(t_valid), .t_ready(t_ready), .t_lane(t_lane),
      .beat_last(beat_last), .col_last(col_last), .done(done), .dbg_state(dbg_state)
   );

   // Clock / reset block
   always #5 clk = ~clk;

   initial begin
      #20_000_000;
      $display("FAIL watchdog: simulation did not reach summary");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int t, k, c, s, o;
      int rmode;      // 0: ready high, 1: pattern 1,0,0,1, 2: random
      int abort_at;   // drop enable after this many handshakes (-1 = never)
      int reset_at;   // pulse rstn after this many handshakes (-1 = never)
      int no_sync;    // start without waiting a negedge (continuation after reset)
      int exp_beats;
   } vec_t;

   typedef struct {
      int cs;
      int idx;
      int addr;
   } probe_t;

   int checks = 0;
   int errors = 0;
   logic [EW-1:0]     exp_q[$];
   logic [ADDR_W-1:0] got_q[$];
   probe_t            probes[$];
   vec_t              vecs[10];

   function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endfunction

   // Reference model: enumerate the im2col stream straight from the loop nest.
   task automatic build_expected(input int t, input int k, input int c, input int s, input int o);
      int a, e, lane, col_n;
      logic bl, cl;
      exp_q.delete();
      col_n = k * k * c;
      for (int orow = 0; orow <= o; orow++)
         for (int ocol = 0; ocol <= o; ocol++) begin
            e = 0;
            for (int ch = 0; ch < c; ch++)
               for (int kr = 0; kr < k; kr++)
                  for (int kc = 0; kc < k; kc++) begin
                     a    = ch * t * t + (orow * s + kr) * t + ocol * s + kc;
                     lane = e % S2P;
                     cl   = (e == col_n - 1);
                     bl   = (lane == S2P - 1) || cl;
                     exp_q.push_back({ADDR_W'(a), LW'(lane), bl, cl});
                     e++;
                  end
         end
   endtask

   // Driver: runs one pass and scoreboards every handshake against exp_q.
   task automatic run_pass(input vec_t v, output int hs);
      int cyc, done_due;
      bit fin, aborting, was_reset, prev_stall;
      logic [EW-1:0] cur, prev, e;
      logic exp_v;
      build_expected(v.t, v.k, v.c, v.s, v.o);
      got_q.delete();
      hs = 0; fin = 0; aborting = 0; was_reset = 0; prev_stall = 0; prev = '0;
      done_due = (exp_q.size() == 0) ? 2 : -1;
      if (v.no_sync == 0) @(negedge clk);
      tensor_size = TENSOR_W'(v.t);
      kernel_size = KERNEL_W'(v.k);
      channels    = CHANNELS_W'(v.c);
      stride      = STRIDE_W'(v.s);
      ofs         = TENSOR_W'(v.o);
      enable      = 1'b1;
      t_ready     = 1'b0;
      cyc = 0;
      while (!fin && cyc < BUDGET) begin
         @(negedge clk);
         cyc++;
         cur = {t_addr, t_lane, beat_last, col_last};
         if (prev_stall) chk("hold_stable", cur, prev);
         prev_stall = 0;
         if (aborting) begin
            chk("abort_valid", t_valid, 0);
            chk("abort_done", done, 0);
            fin = 1;
         end else begin
            exp_v = (cyc >= 2) && (exp_q.size() > 0);
            chk("t_valid", t_valid, exp_v);
            if (cyc == done_due) begin
               chk("done_rise", done, 1);
               fin = 1;
            end else begin
               chk("done_low", done, 0);
               if (v.reset_at >= 0 && hs == v.reset_at && t_valid) begin
                  rstn = 1'b0;
                  #1;
                  chk("rst_addr", t_addr, 0);
                  chk("rst_valid", t_valid, 0);
                  chk("rst_tags", {t_lane, beat_last, col_last}, 0);
                  chk("rst_done", done, 0);
                  @(negedge clk);
                  rstn = 1'b1;
                  was_reset = 1;
                  fin = 1;
               end else if (v.abort_at >= 0 && hs == v.abort_at && t_valid) begin
                  enable = 1'b0;
                  aborting = 1;
               end else begin
                  case (v.rmode)
                     0:       t_ready = 1'b1;
                     1:       t_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                     default: t_ready = ($urandom_range(0, 3) != 0);
                  endcase
                  if (t_valid && t_ready) begin
                     if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("beat", cur, e);
                        if (exp_q.size() == 0) done_due = cyc + 1;
                     end
                     got_q.push_back(t_addr);
                     hs++;
                  end
                  prev_stall = t_valid && !t_ready;
                  prev = cur;
               end
            end
         end
      end
      if (!fin) begin
         checks++;
         errors++;
         $display("FAIL timeout: pass did not finish within %0d cycles, handshakes %0d", BUDGET, hs);
      end
      if (!was_reset) begin
         enable = 1'b0;
         @(negedge clk);
         @(negedge clk);
         chk("idle_done", done, 0);
         chk("idle_valid", t_valid, 0);
      end
   endtask

   task automatic add_probes(input int cs, input int base_idx, input int addrs[$]);
      probe_t p;
      foreach (addrs[i]) begin
         p.cs = cs;
         p.idx = base_idx + i;
         p.addr = addrs[i];
         probes.push_back(p);
      end
   endtask

   initial begin
      int hs, t, k, c, s, o;
      vec_t rv;
      rstn = 1'b0;
      enable = 1'b0;
      t_ready = 1'b0;
      tensor_size = '0; kernel_size = '0; channels = '0; stride = '0; ofs = '0;
      repeat (3) @(negedge clk);
      chk("reset_addr", t_addr, 0);
      chk("reset_valid", t_valid, 0);
      chk("reset_tags", {t_lane, beat_last, col_last}, 0);
      chk("reset_done", done, 0);
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_after_reset", {t_valid, done}, 0);

      //            t  k  c  s  o  rmode abort reset nosync beats
      vecs[0] = '{4, 2, 1, 1, 2, 0, -1, -1, 0, 36};
      vecs[1] = '{5, 3, 1, 2, 1, 0, -1, -1, 0, 36};
      vecs[2] = '{3, 2, 2, 1, 1, 0, -1, -1, 0, 32};
      vecs[3] = '{4, 2, 1, 1, 2, 1, -1, -1, 0, 36};
      vecs[4] = '{4, 2, 1, 1, 2, 0,  5, -1, 0,  5};
      vecs[5] = '{4, 2, 1, 1, 2, 0, -1, -1, 0, 36};
      vecs[6] = '{4, 0, 1, 1, 2, 0, -1, -1, 0,  0};
      vecs[7] = '{4, 2, 0, 1, 2, 0, -1, -1, 0,  0};
      vecs[8] = '{4, 2, 1, 1, 2, 0, -1, 10, 0, 10};
      vecs[9] = '{4, 2, 1, 1, 2, 0, -1, -1, 1, 36};

      add_probes(0, 0, '{0, 1, 4, 5, 1, 2, 5, 6});
      add_probes(1, 0, '{0, 1, 2, 5, 6, 7, 10, 11, 12});
      add_probes(1, 9, '{2, 3, 4, 7, 8, 9, 12, 13, 14});
      add_probes(2, 0, '{0, 1, 3, 4, 9, 10, 12, 13});
      add_probes(2, 24, '{4, 5, 7, 8, 13, 14, 16, 17});
      add_probes(3, 0, '{0, 1, 4, 5, 1, 2, 5, 6});
      add_probes(4, 0, '{0, 1, 4, 5, 1});
      add_probes(5, 0, '{0, 1, 4, 5});
      add_probes(9, 0, '{0, 1, 4, 5});

      for (int i = 0; i < 10; i++) begin
         run_pass(vecs[i], hs);
         chk($sformatf("beats_case%0d", i), hs, vecs[i].exp_beats);
         foreach (probes[j]) begin
            if (probes[j].cs == i)
               chk($sformatf("probe_case%0d_idx%0d", i, probes[j].idx),
                   (probes[j].idx < got_q.size()) ? {48'd0, got_q[probes[j].idx]} : 64'hFFFF_FFFF,
                   probes[j].addr);
         end
      end

      for (int r = 0; r < 12; r++) begin
         t = $urandom_range(1, 8);
         k = $urandom_range(0, 3);
         c = $urandom_range(0, 3);
         s = $urandom_range(1, 3);
         o = $urandom_range(0, 3);
         rv = '{t, k, c, s, o, 2, -1, -1, 0, (o + 1) * (o + 1) * k * k * c};
         run_pass(rv, hs);
         chk($sformatf("beats_rand%0d", r), hs, rv.exp_beats);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
